// File: rtl/uart_dump_tx.sv
// uart_dump_tx
// Serial memory-dump transmitter. On a start request it reads len bytes
// from a synchronous-read memory port, beginning at base_addr, and sends
// them out an 8N1 UART line preceded by a fixed HEADER byte.
//
// Optional feature: define DUMP_CHECKSUM_EN to append a trailer byte
// holding the mod-256 sum of the data bytes (header excluded).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   start      dump request, sampled only while idle
//   base_addr  first memory address, captured when start is accepted
//   len        number of data bytes, captured when start is accepted
//   mem_addr   memory read address (holds its last value between reads)
//   mem_rd     read strobe; mem_data is valid the following cycle
//   mem_data   memory read data
//   tx         UART line, idle high
//   busy       high while a dump is in progress
//   done       single-cycle pulse when the dump has finished
module uart_dump_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_CK_GAP, S_TRAILER, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_DONE
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [ADDR_W-1:0] idx_inc;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  // Whole 10-bit frame {stop, data, start}; shifted right one bit per bit
  // period with ones shifted in, so it drains to all-ones (idle) by itself.
  logic [9:0]        frame_reg, frame_next;
  logic [CNT_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic              mem_rd_reg, busy_reg, done_reg;
  logic              in_frame, bit_tick, frame_end;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        sum_reg, sum_next;
  logic              gap_reg, gap_next;
`endif

  assign tx       = frame_reg[0];
  assign mem_addr = mem_addr_reg;
  assign mem_rd   = mem_rd_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  assign idx_inc   = idx_reg + ADDR_W'(1);
`ifdef DUMP_CHECKSUM_EN
  assign in_frame  = (state_reg == S_HDR) || (state_reg == S_SEND) ||
                     (state_reg == S_TRAILER);
`else
  assign in_frame  = (state_reg == S_HDR) || (state_reg == S_SEND);
`endif
  assign bit_tick  = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign frame_end = in_frame && bit_tick && (bit_cnt_reg == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      base_reg     <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      mem_addr_reg <= '0;
      frame_reg    <= '1;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      mem_rd_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_reg      <= '0;
      gap_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      mem_addr_reg <= mem_addr_next;
      frame_reg    <= frame_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      // Strobes are registered from the next state so they line up
      // exactly with the state they belong to.
      mem_rd_reg   <= (state_next == S_FETCH);
      busy_reg     <= (state_next != S_IDLE) && (state_next != S_DONE);
      done_reg     <= (state_next == S_DONE);
`ifdef DUMP_CHECKSUM_EN
      sum_reg      <= sum_next;
      gap_reg      <= gap_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;
    mem_addr_next = mem_addr_reg;
    frame_next    = frame_reg;
    clk_cnt_next  = clk_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
`ifdef DUMP_CHECKSUM_EN
    sum_next      = sum_reg;
    gap_next      = gap_reg;
`endif

    // Bit timing shared by header, data and trailer frames.
    if (in_frame) begin
      if (bit_tick) begin
        clk_cnt_next = '0;
        frame_next   = {1'b1, frame_reg[9:1]};
        bit_cnt_next = (bit_cnt_reg == 4'd9) ? 4'd0 : bit_cnt_reg + 4'd1;
      end else begin
        clk_cnt_next = clk_cnt_reg + CNT_W'(1);
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          base_next    = base_addr;
          len_next     = len;
          idx_next     = '0;
          frame_next   = {1'b1, HEADER, 1'b0};
          clk_cnt_next = '0;
          bit_cnt_next = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_next     = '0;
`endif
          state_next   = S_HDR;
        end
      end
      S_HDR: begin
        if (frame_end) begin
          if (len_reg == '0) begin
`ifdef DUMP_CHECKSUM_EN
            gap_next   = 1'b0;
            state_next = S_CK_GAP;
`else
            state_next = S_DONE;
`endif
          end else begin
            mem_addr_next = base_reg + idx_reg;
            state_next    = S_FETCH;
          end
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        frame_next   = {1'b1, mem_data, 1'b0};
        clk_cnt_next = '0;
        bit_cnt_next = '0;
`ifdef DUMP_CHECKSUM_EN
        sum_next     = sum_reg + mem_data;
`endif
        state_next   = S_SEND;
      end
      S_SEND: begin
        if (frame_end) begin
          idx_next = idx_inc;
          if (idx_inc == len_reg) begin
`ifdef DUMP_CHECKSUM_EN
            gap_next   = 1'b0;
            state_next = S_CK_GAP;
`else
            state_next = S_DONE;
`endif
          end else begin
            mem_addr_next = base_reg + idx_inc;
            state_next    = S_FETCH;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      // Two idle-high cycles before the trailer, matching the data gap.
      S_CK_GAP: begin
        if (gap_reg) begin
          gap_next     = 1'b0;
          frame_next   = {1'b1, sum_reg, 1'b0};
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = S_TRAILER;
        end else begin
          gap_next = 1'b1;
        end
      end
      S_TRAILER: begin
        if (frame_end) state_next = S_DONE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_dump_tx.sv
// tb_uart_dump_tx
// Self-checking bench for uart_dump_tx (CLKS_PER_BIT=4). Expected bytes and
// read addresses are queued when a dump is requested; a UART receiver and a
// read-strobe monitor pop and compare them as the DUT produces output.
module tb_uart_dump_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] len;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       tx;
  logic       busy;
  logic       done;

  uart_dump_tx #(
    .CLKS_PER_BIT(C),
    .ADDR_W      (8),
    .HEADER      (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  logic [7:0] byte_q[$];
  logic [7:0] addr_q[$];
  bit         first_frame = 1'b0;
  bit         rx_abort    = 1'b0;
  bit         dump_active = 1'b0;
  int         busy_err    = 0;
  int         done_cnt    = 0;
  int         exp_cycles  = 0;
  time        dump_start_t = 0;
  time        prev_start_t = 0;

  // UART receiver: start bit detected at the first negedge it is low,
  // each bit then sampled mid-period.
  bit         rx_active = 1'b0;
  int         rx_t      = 0;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (rst || rx_abort) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        rx_byte   = 8'h00;
        if (first_frame) begin
          first_frame  = 1'b0;
          dump_start_t = $time;
        end else begin
          chk("gap", int'(($time - prev_start_t) / 10) - 10 * C, 2);
        end
        prev_start_t = $time;
      end
    end else begin
      rx_t++;
      if (rx_t == C / 2) begin
        chk("start_bit", {31'd0, tx}, 0);
      end else if (rx_t >= C + C / 2 && rx_t < 9 * C && (rx_t - C / 2) % C == 0) begin
        rx_byte[(rx_t - C / 2) / C - 1] = tx;
      end else if (rx_t == 9 * C + C / 2) begin
        chk("stop_bit", {31'd0, tx}, 1);
        if (byte_q.size() == 0) chk("rx_unexpected", {24'd0, rx_byte}, 32'h100);
        else chk("rx_byte", {24'd0, rx_byte}, {24'd0, byte_q.pop_front()});
        $display("frame 0x%02h received at %0t", rx_byte, $time);
        rx_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_rd === 1'b1) begin
      if (addr_q.size() == 0) chk("rd_unexpected", {24'd0, mem_addr}, 32'h100);
      else chk("rd_addr", {24'd0, mem_addr}, {24'd0, addr_q.pop_front()});
    end
    if (done === 1'b1) done_cnt++;
    if (dump_active && done !== 1'b1 && busy !== 1'b1) busy_err++;
  end

  task automatic start_dump(input logic [7:0] b, input logic [7:0] l);
    logic [7:0] a;
    logic [7:0] s;
    s = 8'h00;
    byte_q.push_back(8'hA5);
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      addr_q.push_back(a);
      byte_q.push_back(mem[a]);
      s = s + mem[a];
    end
    exp_cycles = (int'(l) + 1) * 10 * C + 2 * int'(l);
`ifdef DUMP_CHECKSUM_EN
    byte_q.push_back(s);
    exp_cycles += 10 * C + 2;
`endif
    first_frame = 1'b1;
    @(negedge clk);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dump_active = 1'b1;
    $display("dump requested base=0x%02h len=%0d", b, l);
  endtask

  task automatic wait_done(input string tag);
    bit  seen = 1'b0;
    time t_done = 0;
    for (int t = 0; t < 20000 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen   = 1'b1;
        t_done = $time;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 1);
    if (seen) begin
      chk({tag, "_cycles"}, int'((t_done - dump_start_t) / 10), exp_cycles);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 0);
    end
    dump_active = 1'b0;
    chk({tag, "_busy_held"}, busy_err, 0);
    busy_err = 0;
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, done}, 0);
    chk({tag, "_bytes_left"}, byte_q.size(), 0);
    chk({tag, "_reads_left"}, addr_q.size(), 0);
    $display("dump %s finished, %0d cycles", tag, int'((t_done - dump_start_t) / 10));
  endtask

  int d0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    rst = 1'b1; start = 1'b0; base_addr = 8'h00; len = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: header only
    start_dump(8'h00, 8'd0);
    wait_done("len0");

    // 2: three bytes
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h80; mem[8'h12] = 8'hFF;
    start_dump(8'h10, 8'd3);
    wait_done("len3");

    // 3: address wrap
    mem[8'hFE] = 8'h3C; mem[8'hFF] = 8'hC3; mem[8'h00] = 8'h5A;
    start_dump(8'hFE, 8'd3);
    wait_done("wrap");

    // 4: start re-pulsed during the second data frame is ignored
    start_dump(8'h20, 8'd3);
    repeat (20 * C + 10) @(posedge clk);
    @(negedge clk);
    base_addr = 8'h77; len = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("restart");
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    chk("no_extra_done", done_cnt, d0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_tx", {31'd0, tx}, 1);

    // 5: reset during the start bit of the second data byte
    start_dump(8'h10, 8'd3);
    repeat (20 * C + 6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx}, 0);
    d0 = done_cnt;
    rst = 1'b1; rx_abort = 1'b1; dump_active = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_tx", {31'd0, tx}, 1);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_done", {31'd0, done}, 0);
    byte_q.delete();
    addr_q.delete();
    repeat (5) @(negedge clk);
    rx_abort = 1'b0;
    chk("rst_no_done", done_cnt, d0);
    start_dump(8'h10, 8'd3);
    wait_done("after_rst");

    // 6: checksum data (trailer only when the feature is built in)
    mem[8'h40] = 8'h80; mem[8'h41] = 8'h90;
    start_dump(8'h40, 8'd2);
    wait_done("cksum");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
